muldiv_seq_unit: RTL and testbench
==================================

Name: muldiv_seq_unit

Overview:
Parametrised multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for XLEN-bit operands.
- Replaces the single-cycle loop-unrolled multiply/divide paths in the ALU with an iterative radix-2 datapath.
- Correct signed handling and RISC-V divide-by-zero/overflow semantics.
- Valid/ready handshake on input and output, plus pipeline flush.
- Sits beside the ALU in EX and stalls the pipeline via busy/start_ready.

Parameters:
XLEN, 32, operand/result width (≥8, even).
TAG_W, 5, width of destination tag carried through (rd index).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous abort of any in-flight op.
start_valid  in  1  request valid.
start_ready  out  1  unit can accept (high only in IDLE).
op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
srcA  in  XLEN  rs1 operand.
srcB  in  XLEN  rs2 operand.
tag_in  in  TAG_W  destination tag.
result_valid  out  1  result available.
result_ready  in  1  consumer accepts result.
result  out  XLEN  selected result.
tag_out  out  TAG_W  tag of current result.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - result=0, tag_out=0, result_valid=0, busy=0, start_ready=1.
  - All internal registers cleared.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE → PREP when start_valid && start_ready (cycle T). Latch op, srcA, srcB, tag_in.
- PREP (T+1):
  - Compute operand magnitudes per op signedness:
    - MULH: both signed.
    - MULHSU: A signed, B unsigned.
    - DIV/REM: both signed.
    - Others: unsigned.
  - Record result sign:
    - Multiply/quotient: signA^signB.
    - Remainder: signA.
  - Clear accumulator and iteration counter.
  - Special-case fast path, PREP → DONE directly (result_valid at T+2):
    - Divide by zero (srcB==0, any div op): DIV/DIVU → all-ones; REM/REMU → srcA.
    - Signed overflow (DIV/REM, srcA = 1<<(XLEN-1), srcB = all-ones): DIV → srcA; REM → 0.
  - Otherwise PREP → CALC.
- CALC: exactly XLEN cycles (T+2 .. T+XLEN+1), counter 0..XLEN-1.
  - Multiply: shift-add, one multiplier bit per cycle, 2·XLEN-bit unsigned product.
  - Divide: restoring, one quotient bit per cycle; remainder compare is unsigned on magnitudes.
  - Counter == XLEN-1 → FIX.
- FIX (T+XLEN+2):
  - Apply two's-complement negation if the recorded sign is set (full 2·XLEN for products).
  - Select the result:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register result and tag_out. → DONE.
- DONE (result_valid=1 from T+XLEN+3; from T+2 on the fast path):
  - result/tag_out held stable while result_ready=0.
  - On result_valid && result_ready → IDLE next cycle.
  - A new start in that IDLE cycle is accepted; there is no same-cycle accept in DONE.
- flush=1 in any state → IDLE next cycle. result_valid deasserts next cycle; result is not updated. flush has priority over a result_ready handshake in the same cycle.
- flush in IDLE with start_valid=1: request not accepted.
- Nominal latency, request accept to result_valid: XLEN+3 cycles (35 for XLEN=32); special cases: 2.
- start_ready = (state==IDLE); busy = !start_ready.
- op/srcA/srcB changes after acceptance have no effect.

Test Plan:
1. MUL srcA=7, srcB=0xFFFFFFFD → result=0xFFFFFFEB; result_valid exactly 35 cycles after accept, busy=1 throughout.
2. High-half multiplies:
   - MULH 0x80000000×0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. Divides:
   - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
   - REM 0xFFFFFFF9/2 → 0xFFFFFFFF.
   - DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF.
   - REMU 100/7 → 2.
   - Each 35-cycle latency.
4. Special cases, result_valid 2 cycles after accept:
   - DIV 5/0 → 0xFFFFFFFF.
   - REMU 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
   - REM same operands → 0.
5. Back-pressure and tags:
   - Hold result_ready=0 for 5 cycles in DONE → result/tag_out (tag_in=0x1A) stable, start_ready=0.
   - Then a ready pulse → IDLE next cycle, next request accepted.
6. Flush and reset:
   - flush at CALC cycle 10 → IDLE next cycle, no result_valid ever, immediate new MUL 3×4 → 12.
   - reset asserted asynchronously mid-CALC → all outputs 0, start_ready=1 without a clock edge.

Source files
------------

// File: rtl/muldiv_seq_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master side (pipeline) issues requests and consumes results; the slave side is the unit.
interface muldiv_seq_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       op;
    logic [XLEN-1:0]  srcA;
    logic [XLEN-1:0]  srcB;
    logic [TAG_W-1:0] tag_in;
    logic             result_valid;
    logic             result_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    modport master (
        output flush, start_valid, op, srcA, srcB, tag_in, result_ready,
        input  start_ready, result_valid, result, tag_out, busy
    );

    modport slave (
        input  flush, start_valid, op, srcA, srcB, tag_in, result_ready,
        output start_ready, result_valid, result, tag_out, busy
    );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide.
// Operands are reduced to magnitudes in PREP, iterated XLEN times in CALC, and the
// sign is reapplied in FIX. Divide-by-zero and signed overflow skip straight to DONE.
module muldiv_seq_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    muldiv_seq_unit_if.slave     bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] CALC = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [2:0]        op_q,      op_d;
    logic [XLEN-1:0]   a_q,       a_d;
    logic [XLEN-1:0]   b_q,       b_d;
    logic [TAG_W-1:0]  tag_q,     tag_d;
    logic [XLEN-1:0]   mag_a_q,   mag_a_d;
    logic [XLEN-1:0]   mag_b_q,   mag_b_d;
    logic              neg_q,     neg_d;
    logic [2*XLEN-1:0] acc_q,     acc_d;   // product, or {remainder, quotient}
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [XLEN-1:0]   res_q,     res_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;

    // Operand classification for the latched op
    logic is_div, a_signed, b_signed, sa, sb;
    assign is_div   = op_q[2];
    assign a_signed = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    assign b_signed = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    assign sa       = a_signed && a_q[XLEN-1];
    assign sb       = b_signed && b_q[XLEN-1];

    // One iteration of each datapath. The divide trial always fits once the
    // remainder stays below the divisor, so only the low XLEN bits of the difference matter.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
    assign div_trial = {acc_q[2*XLEN-1:XLEN], mag_a_q[XLEN-1]};
    assign div_ge    = div_trial >= {1'b0, mag_b_q};
    assign div_diff  = div_trial[XLEN-1:0] - mag_b_q;

    // Sign fix-up of the raw results
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    // Next-state and datapath control; flush overrides every transition
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        tag_out_d = tag_out_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid && !bus.flush) begin
                    op_d    = bus.op;
                    a_d     = bus.srcA;
                    b_d     = bus.srcB;
                    tag_d   = bus.tag_in;
                    state_d = PREP;
                end
            end
            PREP: begin
                mag_a_d = sa ? -a_q : a_q;
                mag_b_d = sb ? -b_q : b_q;
                neg_d   = (is_div && op_q[1]) ? sa : (sa ^ sb);
                acc_d   = '0;
                cnt_d   = '0;
                if (is_div && b_q == '0) begin
                    res_d     = op_q[1] ? a_q : '1;
                    tag_out_d = tag_q;
                    state_d   = DONE;
                end else if (is_div && !op_q[0] && a_q == SMIN && b_q == '1) begin
                    res_d     = op_q[1] ? '0 : a_q;
                    tag_out_d = tag_q;
                    state_d   = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!is_div) begin
                    acc_d   = {mul_sum, acc_q[XLEN-1:1]};
                    mag_b_d = mag_b_q >> 1;
                end else begin
                    acc_d   = {(div_ge ? div_diff : div_trial[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
                    mag_a_d = mag_a_q << 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                case (op_q)
                    3'b000:                 res_d = prod_fix[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: res_d = prod_fix[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         res_d = quo_fix;
                    default:                res_d = rem_fix;
                endcase
                tag_out_d = tag_q;
                state_d   = DONE;
            end
            DONE: begin
                if (bus.result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign bus.result       = res_q;
    assign bus.tag_out      = tag_out_q;
    assign bus.result_valid = (state_q == DONE);
    assign bus.start_ready  = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit (XLEN=32): results, latency, back-pressure, flush, reset.
module tb_muldiv_seq_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    muldiv_seq_unit_if #(.XLEN(32), .TAG_W(5)) bus ();

    muldiv_seq_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for result_valid (bounded), check value, tag, latency, busy.
    // With hold set the result is left pending in DONE.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp,
                          input int exp_lat, input bit hold);
        int n;
        bit busy_ok;
        check({tag, " start_ready"}, {63'd0, bus.start_ready}, 64'd1);
        bus.op = o; bus.srcA = a; bus.srcB = b; bus.tag_in = t; bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        bus.op = ~o; bus.srcA = ~a; bus.srcB = ~b; bus.tag_in = ~t;
        n = 1;
        busy_ok = 1'b1;
        while (!bus.result_valid && n < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " result"}, {32'd0, bus.result}, {32'd0, exp});
        check({tag, " tag"}, {59'd0, bus.tag_out}, {59'd0, t});
        check({tag, " busy"}, {63'd0, busy_ok}, 64'd1);
        if (!hold) begin
            bus.result_ready = 1'b1;
            tick();
            bus.result_ready = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        bus.flush = 1'b0; bus.start_valid = 1'b0; bus.op = '0; bus.srcA = '0;
        bus.srcB = '0; bus.tag_in = '0; bus.result_ready = 1'b0;
        #12;
        check("rst result", {32'd0, bus.result}, 64'd0);
        check("rst tag", {59'd0, bus.tag_out}, 64'd0);
        check("rst valid", {63'd0, bus.result_valid}, 64'd0);
        check("rst busy", {63'd0, bus.busy}, 64'd0);
        check("rst start_ready", {63'd0, bus.start_ready}, 64'd1);
        @(negedge clk) reset = 1'b0;
        tick();

        run_op("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 35, 1'b0);
        run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 35, 1'b0);
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 35, 1'b0);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 35, 1'b0);
        run_op("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 35, 1'b0);
        run_op("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 35, 1'b0);
        run_op("DIVU", 3'b101, 32'hFFFF_FFFE, 32'd2, 5'd7, 32'h7FFF_FFFF, 35, 1'b0);
        run_op("REMU", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 35, 1'b0);

        run_op("DIV0", 3'b100, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("REMU0", 3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 2, 1'b0);
        run_op("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2, 1'b0);
        run_op("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 2, 1'b0);

        // Back-pressure: result and tag must hold while the consumer stalls
        run_op("BP", 3'b101, 32'd100, 32'd7, 5'h1A, 32'd14, 35, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("BP hold result", {32'd0, bus.result}, 64'd14);
            check("BP hold tag", {59'd0, bus.tag_out}, 64'h1A);
            check("BP hold valid", {63'd0, bus.result_valid}, 64'd1);
            check("BP hold start_ready", {63'd0, bus.start_ready}, 64'd0);
        end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("BP idle start_ready", {63'd0, bus.start_ready}, 64'd1);
        check("BP idle valid", {63'd0, bus.result_valid}, 64'd0);
        run_op("BP next", 3'b000, 32'd5, 32'd6, 5'd13, 32'd30, 35, 1'b0);

        // Flush in IDLE blocks acceptance
        bus.flush = 1'b1; bus.start_valid = 1'b1; bus.op = 3'b000;
        tick();
        bus.flush = 1'b0; bus.start_valid = 1'b0;
        check("flush idle busy", {63'd0, bus.busy}, 64'd0);

        // Flush at CALC iteration 10
        bus.op = 3'b101; bus.srcA = 32'd100; bus.srcB = 32'd7; bus.tag_in = 5'd14;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        repeat (11) tick();
        check("flush pre busy", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush start_ready", {63'd0, bus.start_ready}, 64'd1);
        check("flush valid", {63'd0, bus.result_valid}, 64'd0);
        check("flush result kept", {32'd0, bus.result}, 64'd30);
        run_op("MUL after flush", 3'b000, 32'd3, 32'd4, 5'd15, 32'd12, 35, 1'b0);

        // Idle with nothing pending: result_valid must stay low
        seen = 1'b0;
        repeat (10) begin
            if (bus.result_valid) seen = 1'b1;
            tick();
        end
        check("idle no valid", {63'd0, seen}, 64'd0);

        // Asynchronous reset mid-CALC
        bus.op = 3'b000; bus.srcA = 32'd7; bus.srcB = 32'd9; bus.tag_in = 5'd16;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        check("arst result", {32'd0, bus.result}, 64'd0);
        check("arst tag", {59'd0, bus.tag_out}, 64'd0);
        check("arst valid", {63'd0, bus.result_valid}, 64'd0);
        check("arst busy", {63'd0, bus.busy}, 64'd0);
        check("arst start_ready", {63'd0, bus.start_ready}, 64'd1);
        @(negedge clk) reset = 1'b0;
        tick();
        run_op("DIV neg", 3'b100, 32'd100, 32'hFFFF_FFF9, 5'd17, 32'hFFFF_FFF2, 35, 1'b0);
        run_op("REM neg", 3'b110, 32'd100, 32'hFFFF_FFF9, 5'd18, 32'd2, 35, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
